// File: rtl/az_sequencer_pkg.sv
// Shared definitions for the auto-zero sequencer: vector layout, mux codes,
// state encoding and the conditioning-vector builder.
package az_sequencer_pkg;

  localparam int COND_W     = 14;
  localparam int DEF_CNT_W  = 32;

  localparam int AZMUX_LSB  = 0;
  localparam int HIMUX_LSB  = 4;
  localparam int HIMUX2_LSB = 8;
  localparam int PC_BIT     = 12;
  localparam int LED_BIT    = 13;

  localparam logic [3:0] SOFF = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ZERO_SETTLE,
    ST_ZERO,
    ST_SIG_PC,
    ST_SIG
  } state_t;

  // Conditioning vector driven while sitting in state st.
  function automatic logic [COND_W-1:0] build_cond(
    input state_t     st,
    input logic [3:0] az_zero,
    input logic [3:0] az_sig,
    input logic [3:0] hi,
    input logic [3:0] hi2,
    input logic       led
  );
    logic [COND_W-1:0] v;
    v = '0;
    if (st != ST_IDLE) begin
      v[AZMUX_LSB +: 4]  = (st == ST_ZERO_SETTLE || st == ST_ZERO) ? az_zero : az_sig;
      v[HIMUX_LSB +: 4]  = hi;
      v[HIMUX2_LSB +: 4] = hi2;
      v[PC_BIT]          = (st == ST_SIG);
      v[LED_BIT]         = led;
    end else begin
      v[AZMUX_LSB +: 4]  = SOFF;
    end
    return v;
  endfunction

endpackage

// File: rtl/az_sequencer_phase_timer.sv
// Per-phase down-counter: loaded on phase entry, done flags the final clock.
// A zero length loads as a one-clock phase; the count holds at zero.
module az_sequencer_phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (len == '0) ? '0 : len - CNT_W'(1);
    end else if (!done) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/az_sequencer.sv
// Auto-zero modulation sequencer: cycles zero/signal apertures with settle and
// precharge gaps, pulses sample_valid per aperture and interrupts per signal.
module az_sequencer
  import az_sequencer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        azmux_zero,
  input  logic [3:0]        azmux_sig,
  input  logic [3:0]        himux,
  input  logic [3:0]        himux2,
  input  logic [CNT_W-1:0]  settle_cnt,
  input  logic [CNT_W-1:0]  precharge_cnt,
  input  logic [CNT_W-1:0]  aperture_cnt,
  input  logic              int_ack,
  output logic [COND_W-1:0] conditioning_out,
  output logic              sample_valid,
  output logic              sample_phase,
  output logic              interrupt_out,
  output logic              overrun
);

  state_t           state, next_state;
  logic             load, done;
  logic [CNT_W-1:0] len;
  logic             led, led_next;
  logic             start, end_zero, end_sig;

  az_sequencer_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .len   (len),
    .done  (done)
  );

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    len        = settle_cnt;
    if (!enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          next_state = ST_ZERO_SETTLE;
          load       = 1'b1;
          len        = settle_cnt;
        end
        ST_ZERO_SETTLE: if (done) begin
          next_state = ST_ZERO;
          load       = 1'b1;
          len        = aperture_cnt;
        end
        ST_ZERO: if (done) begin
          next_state = ST_SIG_PC;
          load       = 1'b1;
          len        = precharge_cnt;
        end
        ST_SIG_PC: if (done) begin
          next_state = ST_SIG;
          load       = 1'b1;
          len        = aperture_cnt;
        end
        ST_SIG: if (done) begin
          next_state = ST_ZERO_SETTLE;
          load       = 1'b1;
          len        = settle_cnt;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Phase-end events are suppressed when enable drops on the same clock.
  assign start    = enable && (state == ST_IDLE);
  assign end_zero = enable && (state == ST_ZERO) && done;
  assign end_sig  = enable && (state == ST_SIG) && done;
  assign led_next = (next_state == ST_IDLE) ? 1'b0 : (led ^ end_sig);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      led              <= 1'b0;
      conditioning_out <= '0;
      sample_valid     <= 1'b0;
      sample_phase     <= 1'b0;
      interrupt_out    <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state            <= next_state;
      led              <= led_next;
      conditioning_out <= build_cond(next_state, azmux_zero, azmux_sig,
                                     himux, himux2, led_next);
      sample_valid     <= end_zero || end_sig;
      if (end_zero || end_sig) sample_phase <= end_sig;

      // A new interrupt beats a simultaneous ack.
      if (end_sig) begin
        interrupt_out <= 1'b1;
        if (interrupt_out && !int_ack) overrun <= 1'b1;
      end else if (int_ack) begin
        interrupt_out <= 1'b0;
      end
      if (start) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_az_sequencer.sv
// Self-checking bench: a phase-level model checked every cycle, plus directed
// scenarios with hand-computed conditioning words and pulse timings.
module tb_az_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  azmux_zero, azmux_sig, himux, himux2;
  logic [31:0] settle_cnt, precharge_cnt, aperture_cnt;
  logic        int_ack;
  logic [13:0] conditioning_out;
  logic        sample_valid, sample_phase, interrupt_out, overrun;

  int checks = 0;
  int errors = 0;

  az_sequencer dut (
    .clk              (clk),
    .reset            (rst),
    .enable           (enable),
    .azmux_zero       (azmux_zero),
    .azmux_sig        (azmux_sig),
    .himux            (himux),
    .himux2           (himux2),
    .settle_cnt       (settle_cnt),
    .precharge_cnt    (precharge_cnt),
    .aperture_cnt     (aperture_cnt),
    .int_ack          (int_ack),
    .conditioning_out (conditioning_out),
    .sample_valid     (sample_valid),
    .sample_phase     (sample_phase),
    .interrupt_out    (interrupt_out),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Phase-level model: phase 0 idle, 1 settle, 2 zero, 3 precharge, 4 signal.
  int          m_ph, m_rem;
  bit          m_led, m_irq, m_ovr, m_sv, m_sp, m_set;
  logic [13:0] m_cond;

  function automatic int plen(input logic [31:0] v);
    return (v == 0) ? 1 : int'(v);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_rem = 0; m_led = 0; m_irq = 0; m_ovr = 0;
      m_sv = 0; m_sp = 0; m_cond = '0;
    end else begin
      m_sv  = 0;
      m_set = 0;
      if (!enable) begin
        m_ph  = 0;
        m_led = 0;
      end else if (m_ph == 0) begin
        m_ph = 1; m_rem = plen(settle_cnt); m_ovr = 0;
      end else if (m_rem > 1) begin
        m_rem--;
      end else begin
        case (m_ph)
          1: begin m_ph = 2; m_rem = plen(aperture_cnt); end
          2: begin m_sv = 1; m_sp = 0; m_ph = 3; m_rem = plen(precharge_cnt); end
          3: begin m_ph = 4; m_rem = plen(aperture_cnt); end
          default: begin
            m_sv = 1; m_sp = 1; m_set = 1; m_led = !m_led;
            m_ph = 1; m_rem = plen(settle_cnt);
          end
        endcase
      end
      if (m_set) begin
        if (m_irq && !int_ack) m_ovr = 1;
        m_irq = 1;
      end else if (int_ack) begin
        m_irq = 0;
      end
      m_cond = (m_ph == 0) ? 14'd0 :
               {m_led, (m_ph == 4), himux2, himux, (m_ph <= 2) ? azmux_zero : azmux_sig};
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_cond", 32'(conditioning_out), 32'(m_cond));
      check("model_valid", 32'(sample_valid), 32'(m_sv));
      if (m_sv) check("model_phase", 32'(sample_phase), 32'(m_sp));
      check("model_irq", 32'(interrupt_out), 32'(m_irq));
      check("model_ovr", 32'(overrun), 32'(m_ovr));
    end
  end

  logic [13:0] cap_cond [1:40];
  logic        cap_sv   [1:40];
  logic        cap_sp   [1:40];
  logic        cap_irq  [1:40];
  logic        cap_ovr  [1:40];

  // Cycle k is the state after the k-th rising edge of the run.
  task automatic run_cycles(input int n, input int ack_from, input int ack_to,
                            input int chg_at, input logic [31:0] new_ap);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cap_cond[k] = conditioning_out;
      cap_sv[k]   = sample_valid;
      cap_sp[k]   = sample_phase;
      cap_irq[k]  = interrupt_out;
      cap_ovr[k]  = overrun;
      int_ack     = (k >= ack_from) && (k <= ack_to);
      if (k == chg_at) aperture_cnt = new_ap;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; int_ack = 1'b0;
    azmux_zero = 4'b1011; azmux_sig = 4'b1000; himux = 4'h5; himux2 = 4'hA;
    settle_cnt = 2; precharge_cnt = 3; aperture_cnt = 4;

    // Reset held with enable high: everything stays at zero.
    repeat (3) @(negedge clk);
    check("rst_cond", 32'(conditioning_out), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("rst_irq", 32'(interrupt_out), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);

    // Nominal 2/4/3/4 sequence, never acked.
    rst = 1'b0;
    run_cycles(28, 0, 0, 0, 0);
    check("start_settle", 32'(cap_cond[1]), 32'h0A5B);
    check("zero_last", 32'(cap_cond[6]), 32'h0A5B);
    check("zero_no_pulse", 32'(cap_sv[6]), 32'h0);
    check("pc_first", 32'(cap_cond[7]), 32'h0A58);
    check("zero_end_valid", 32'(cap_sv[7]), 32'h1);
    check("zero_end_phase", 32'(cap_sp[7]), 32'h0);
    check("pc_last", 32'(cap_cond[9]), 32'h0A58);
    check("sig_first", 32'(cap_cond[10]), 32'h1A58);
    check("sig_last", 32'(cap_cond[13]), 32'h1A58);
    check("sig_no_early_pulse", 32'(cap_sv[13]), 32'h0);
    check("led_toggle_1", 32'(cap_cond[14]), 32'h2A5B);
    check("sig_end_valid", 32'(cap_sv[14]), 32'h1);
    check("sig_end_phase", 32'(cap_sp[14]), 32'h1);
    check("irq_set", 32'(cap_irq[14]), 32'h1);
    check("zero2_end_valid", 32'(cap_sv[20]), 32'h1);
    check("no_ovr_yet", 32'(cap_ovr[26]), 32'h0);
    check("led_toggle_2", 32'(cap_cond[27]), 32'h0A5B);
    check("overrun_set", 32'(cap_ovr[27]), 32'h1);

    // Stop with ack: interrupt clears, overrun holds until the next start.
    enable = 1'b0; int_ack = 1'b1;
    @(negedge clk);
    check("idle_cond", 32'(conditioning_out), 32'h0);
    check("ack_clears_irq", 32'(interrupt_out), 32'h0);
    check("ovr_held_idle", 32'(overrun), 32'h1);
    int_ack = 1'b0; enable = 1'b1;
    run_cycles(28, 26, 27, 0, 0);
    check("start_clears_ovr", 32'(cap_ovr[1]), 32'h0);
    check("irq_set_again", 32'(cap_irq[14]), 32'h1);
    check("set_wins_irq", 32'(cap_irq[27]), 32'h1);
    check("set_wins_ovr", 32'(cap_ovr[27]), 32'h0);
    check("ack_after", 32'(cap_irq[28]), 32'h0);

    // Abort on the last SIG clock: no pulse, no interrupt.
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    run_cycles(13, 0, 0, 0, 0);
    check("abort_in_sig", 32'(cap_cond[13]), 32'h1A58);
    enable = 1'b0;
    @(negedge clk);
    check("abort_cond", 32'(conditioning_out), 32'h0);
    check("abort_valid", 32'(sample_valid), 32'h0);
    check("abort_irq", 32'(interrupt_out), 32'h0);

    // All lengths zero: one clock per phase, period 4.
    settle_cnt = 0; precharge_cnt = 0; aperture_cnt = 0;
    @(negedge clk);
    enable = 1'b1;
    run_cycles(9, 0, 0, 0, 0);
    check("z_settle", 32'(cap_cond[1]), 32'h0A5B);
    check("z_zero", 32'(cap_cond[2]), 32'h0A5B);
    check("z_pc", 32'(cap_cond[3]), 32'h0A58);
    check("z_zero_valid", 32'(cap_sv[3]), 32'h1);
    check("z_sig", 32'(cap_cond[4]), 32'h1A58);
    check("z_sig_novalid", 32'(cap_sv[4]), 32'h0);
    check("z_wrap", 32'(cap_cond[5]), 32'h2A5B);
    check("z_sig_valid", 32'(cap_sp[5]), 32'h1);
    check("z_period", 32'(cap_cond[9]), 32'h0A5B);

    // Aperture change mid-ZERO: ZERO keeps 4, SIG uses 2.
    enable = 1'b0; int_ack = 1'b1;
    settle_cnt = 2; precharge_cnt = 3; aperture_cnt = 4;
    @(negedge clk);
    int_ack = 1'b0; enable = 1'b1;
    run_cycles(14, 0, 0, 4, 2);
    check("chg_ovr_cleared", 32'(cap_ovr[1]), 32'h0);
    check("chg_zero_kept", 32'(cap_sv[5]), 32'h0);
    check("chg_zero_last", 32'(cap_cond[6]), 32'h0A5B);
    check("chg_zero_end", 32'(cap_sv[7]), 32'h1);
    check("chg_sig", 32'(cap_cond[11]), 32'h1A58);
    check("chg_sig_end", 32'(cap_cond[12]), 32'h2A5B);
    check("chg_sig_valid", 32'(cap_sv[12]), 32'h1);
    check("chg_sig_phase", 32'(cap_sp[12]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
